core_apb_master: RTL and testbench

CORE_APB_MASTER -- requirements
Module: core_apb_master

---
 rtl/core_apb_pkg.sv | 21 ++
 rtl/core_apb_if.sv | 40 ++++
 rtl/core_apb_wdog.sv | 28 ++
 rtl/core_apb_master.sv | 106 ++++++++++
 tb/tb_core_apb_master.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_apb_pkg.sv
// Shared types and constants for the APB3 command-to-bus master and its wait-state watchdog.
package core_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apbState_t;

    // Bus phase expressed as {PSEL, PENABLE}.
    typedef logic [1:0] apbPhase_t;
    localparam apbPhase_t APB_PHASE_IDLE   = 2'b00;
    localparam apbPhase_t APB_PHASE_SETUP  = 2'b10;
    localparam apbPhase_t APB_PHASE_ACCESS = 2'b11;

    localparam int TIMEOUT_DEFAULT = 16;
    localparam int WDOG_WIDTH      = 16;
    localparam logic [WDOG_WIDTH-1:0] WDOG_ONE = WDOG_WIDTH'(1);

endpackage

// File: rtl/core_apb_if.sv
// Command/response handshake plus APB3 completer signals seen by the master core.
interface core_apb_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  CMDVALID;
    logic                  CMDREADY;
    logic [ADDR_WIDTH-1:0] CMDADDR;
    logic                  CMDWRITE;
    logic [31:0]           CMDWDATA;

    logic                  RSPVALID;
    logic                  RSPREADY;
    logic [31:0]           RSPRDATA;
    logic                  RSPERR;
    logic                  RSPTO;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [31:0]           PWDATA;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  CMDVALID, CMDADDR, CMDWRITE, CMDWDATA, RSPREADY,
        input  PRDATA, PREADY, PSLVERR,
        output CMDREADY, RSPVALID, RSPRDATA, RSPERR, RSPTO,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output CMDVALID, CMDADDR, CMDWRITE, CMDWDATA, RSPREADY,
        output PRDATA, PREADY, PSLVERR,
        input  CMDREADY, RSPVALID, RSPRDATA, RSPERR, RSPTO,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/core_apb_wdog.sv
// Saturating ACCESS wait-state counter; expired flags the wait cycle that reaches the limit.
module core_apb_wdog
    import core_apb_pkg::*;
(
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  clear,
    input  logic                  countEn,
    input  logic [WDOG_WIDTH-1:0] limit,
    output logic                  expired
);

    logic [WDOG_WIDTH-1:0] waitCountReg;
    logic [WDOG_WIDTH:0]   countNext;

    // Expiry looks one count ahead so the limit-th wait cycle itself ends the transfer.
    assign countNext = {1'b0, waitCountReg} + (WDOG_WIDTH+1)'(1);
    assign expired   = countEn && (limit != '0) && (countNext >= {1'b0, limit});

    always_ff @(posedge PCLK) begin
        if (PRESET || clear) begin
            waitCountReg <= '0;
        end else if (countEn && (waitCountReg != '1)) begin
            waitCountReg <= waitCountReg + WDOG_ONE;
        end
    end

endmodule

// File: rtl/core_apb_master.sv
// Single-outstanding APB3 master: accepts one command, runs SETUP/ACCESS, returns a response.
module core_apb_master
    import core_apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic       PCLK,
    input  logic       PRESET,
    core_apb_if.master bus
);

    localparam logic [WDOG_WIDTH-1:0] WAIT_LIMIT = WDOG_WIDTH'(TIMEOUT);

    apbState_t             stateReg;
    apbPhase_t             phaseReg;
    logic [ADDR_WIDTH-1:0] pAddrReg;
    logic                  pWriteReg;
    logic [31:0]           pWdataReg;
    logic                  rspValidReg;
    logic [31:0]           rspRdataReg;
    logic                  rspErrReg;
    logic                  rspToReg;
    logic                  wdogExpired;

    core_apb_wdog wdog (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .clear   (stateReg == SETUP),
        .countEn ((stateReg == ACCESS) && !bus.PREADY),
        .limit   (WAIT_LIMIT),
        .expired (wdogExpired)
    );

    // Gated by reset so no command can be taken while reset is asserted.
    assign bus.CMDREADY = (stateReg == IDLE) && !PRESET;
    assign bus.PSEL     = phaseReg[1];
    assign bus.PENABLE  = phaseReg[0];
    assign bus.PADDR    = pAddrReg;
    assign bus.PWRITE   = pWriteReg;
    assign bus.PWDATA   = pWdataReg;
    assign bus.RSPVALID = rspValidReg;
    assign bus.RSPRDATA = rspRdataReg;
    assign bus.RSPERR   = rspErrReg;
    assign bus.RSPTO    = rspToReg;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            stateReg    <= IDLE;
            phaseReg    <= APB_PHASE_IDLE;
            pAddrReg    <= '0;
            pWriteReg   <= 1'b0;
            pWdataReg   <= '0;
            rspValidReg <= 1'b0;
            rspRdataReg <= '0;
            rspErrReg   <= 1'b0;
            rspToReg    <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    // Bus address/data only move here, so they hold while PSEL is low.
                    if (bus.CMDVALID) begin
                        pAddrReg  <= bus.CMDADDR;
                        pWriteReg <= bus.CMDWRITE;
                        pWdataReg <= bus.CMDWDATA;
                        phaseReg  <= APB_PHASE_SETUP;
                        stateReg  <= SETUP;
                    end
                end
                SETUP: begin
                    phaseReg <= APB_PHASE_ACCESS;
                    stateReg <= ACCESS;
                end
                ACCESS: begin
                    // PREADY is tested first so a completion on the limit cycle wins.
                    if (bus.PREADY) begin
                        rspRdataReg <= pWriteReg ? 32'h0 : bus.PRDATA;
                        rspErrReg   <= bus.PSLVERR;
                        rspToReg    <= 1'b0;
                        rspValidReg <= 1'b1;
                        phaseReg    <= APB_PHASE_IDLE;
                        stateReg    <= RESP;
                    end else if (wdogExpired) begin
                        rspRdataReg <= 32'h0;
                        rspErrReg   <= 1'b1;
                        rspToReg    <= 1'b1;
                        rspValidReg <= 1'b1;
                        phaseReg    <= APB_PHASE_IDLE;
                        stateReg    <= RESP;
                    end
                end
                RESP: begin
                    if (bus.RSPREADY) begin
                        rspValidReg <= 1'b0;
                        stateReg    <= IDLE;
                    end
                end
                default: begin
                    phaseReg <= APB_PHASE_IDLE;
                    stateReg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_apb_master.sv
// Randomized scoreboard bench for core_apb_master with a behavioural APB completer model.
module tb_core_apb_master;

    localparam int AW      = 12;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [31:0]   wdata;
        int            waits;     // PREADY low cycles before completion
        logic          slverr;
        logic [31:0]   rdata;
        int            rspDelay;  // RSPREADY low cycles while RSPVALID is high
    } plan_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          rspDelay;
    } exp_t;

    logic PCLK = 1'b0;
    logic PRESET;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acceptCyc = 0;
    bit   aborting = 1'b1;
    logic [AW-1:0] lastAddr = '0;
    logic [31:0]   lastWdata = '0;

    plan_t planQ[$];
    exp_t  expQ[$];

    core_apb_if #(.ADDR_WIDTH(AW)) bus ();

    core_apb_master #(.ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus.master)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=event (cycle %0d)", name, cyc);
    endtask

    function automatic bit isTimeout(input plan_t p);
        return (TIMEOUT > 0) && (p.waits >= TIMEOUT);
    endfunction

    function automatic exp_t model(input plan_t p);
        exp_t e;
        e.rspDelay = p.rspDelay;
        if (isTimeout(p)) begin
            e.rdata = 32'h0; e.err = 1'b1; e.to = 1'b1;
        end else begin
            e.rdata = p.write ? 32'h0 : p.rdata; e.err = p.slverr; e.to = 1'b0;
        end
        return e;
    endfunction

    function automatic int accessCycles(input plan_t p);
        return isTimeout(p) ? TIMEOUT : p.waits + 1;
    endfunction

    function automatic plan_t mk(input logic [AW-1:0] a, input logic w, input logic [31:0] wd,
                                 input int wt, input logic se, input logic [31:0] rd, input int rdly);
        plan_t p;
        p.addr = a; p.write = w; p.wdata = wd; p.waits = wt;
        p.slverr = se; p.rdata = rd; p.rspDelay = rdly;
        return p;
    endfunction

    // APB completer: follows the plan of the transfer in flight and checks bus timing/stability.
    initial begin
        plan_t cur;
        int accessCnt = 0;
        bit rdy;
        bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERR = 1'b0;
        cur = mk('0, 1'b0, '0, 0, 1'b0, '0, 0);
        forever begin
            @(negedge PCLK);
            if (bus.CMDVALID && bus.CMDREADY) acceptCyc = cyc;
            if (bus.PSEL && !bus.PENABLE) chk("setup_latency", cyc, acceptCyc + 1);
            if (bus.PSEL && bus.PENABLE) begin
                if (accessCnt == 0) begin
                    chk("access_latency", cyc, acceptCyc + 2);
                    if (planQ.size() == 0) failNow("plan_underflow");
                    else cur = planQ.pop_front();
                end
                accessCnt++;
                chk("paddr", 32'(bus.PADDR), 32'(cur.addr));
                chk("pwrite", 32'(bus.PWRITE), 32'(cur.write));
                chk("pwdata", bus.PWDATA, cur.wdata);
                lastAddr  = bus.PADDR;
                lastWdata = bus.PWDATA;
                rdy = (accessCnt - 1 == cur.waits);
                bus.PREADY  = rdy;
                bus.PRDATA  = rdy ? cur.rdata : $urandom;
                bus.PSLVERR = rdy ? cur.slverr : 1'($urandom);
            end else begin
                if (accessCnt > 0 && !aborting) begin
                    chk("access_cycles", accessCnt, accessCycles(cur));
                    chk("rspvalid_latency", 32'(bus.RSPVALID), 32'd1);
                end
                accessCnt = 0;
                bus.PREADY = 1'b0;
                if (!bus.PSEL && !aborting) begin
                    chk("paddr_retain", 32'(bus.PADDR), 32'(lastAddr));
                    chk("pwdata_retain", bus.PWDATA, lastWdata);
                end
            end
        end
    end

    // Response scoreboard: owns RSPREADY, pops the expected response on each handshake.
    initial begin
        exp_t e;
        int vcnt = 0;
        bit justDone = 1'b0;
        logic [33:0] held = '0;
        bus.RSPREADY = 1'b0;
        forever begin
            @(negedge PCLK);
            if (justDone) begin
                chk("rspvalid_fall", 32'(bus.RSPVALID), 32'd0);
                justDone = 1'b0;
                bus.RSPREADY = 1'b0;
                vcnt = 0;
            end else if (bus.RSPVALID) begin
                chk("cmdready_busy", 32'(bus.CMDREADY), 32'd0);
                vcnt++;
                if (vcnt == 1) held = {bus.RSPRDATA, bus.RSPERR, bus.RSPTO};
                else chk("rsp_stable", 32'({bus.RSPERR, bus.RSPTO, bus.RSPRDATA[29:0]}),
                         32'({held[1:0], held[31:2]}));
                if (expQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected actual=rdata 0x%08h expected=no response", bus.RSPRDATA);
                    bus.RSPREADY = 1'b1; justDone = 1'b1;
                end else if (vcnt > expQ[0].rspDelay) begin
                    e = expQ.pop_front();
                    chk("rsp_rdata", bus.RSPRDATA, e.rdata);
                    chk("rsp_err", 32'(bus.RSPERR), 32'(e.err));
                    chk("rsp_to", 32'(bus.RSPTO), 32'(e.to));
                    $display("rsp rdata=0x%08h err=%0b to=%0b held=%0d", bus.RSPRDATA, bus.RSPERR, bus.RSPTO, vcnt);
                    bus.RSPREADY = 1'b1; justDone = 1'b1;
                end else begin
                    bus.RSPREADY = 1'b0;
                end
            end else begin
                if (vcnt > 0) chk("rsp_dropped", 32'(bus.RSPVALID), 32'd1);
                vcnt = 0;
                bus.RSPREADY = 1'b0;
            end
        end
    end

    task automatic issue(input plan_t p);
        int n = 0;
        planQ.push_back(p);
        expQ.push_back(model(p));
        bus.CMDADDR = p.addr; bus.CMDWRITE = p.write; bus.CMDWDATA = p.wdata; bus.CMDVALID = 1'b1;
        do begin @(negedge PCLK); n++; end while (!bus.CMDREADY && n < 500);
        if (!bus.CMDREADY) failNow("cmd_accept");
        @(posedge PCLK); #1;
        $display("cmd addr=0x%03h write=%0b wdata=0x%08h waits=%0d slverr=%0b rspDelay=%0d",
                 p.addr, p.write, p.wdata, p.waits, p.slverr, p.rspDelay);
        bus.CMDVALID = 1'b0; bus.CMDADDR = AW'($urandom); bus.CMDWDATA = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while ((expQ.size() != 0 || bus.RSPVALID) && n < 2000) begin @(negedge PCLK); n++; end
        if (n >= 2000) failNow("drain");
        @(posedge PCLK); #1;
    endtask

    initial begin
        plan_t p;
        int n, r, waits;
        PRESET = 1'b1;
        bus.CMDVALID = 1'b0; bus.CMDADDR = '0; bus.CMDWRITE = 1'b0; bus.CMDWDATA = '0;
        repeat (2) @(negedge PCLK);
        chk("rst_cmdready", 32'(bus.CMDREADY), 32'd0);
        chk("rst_psel", 32'(bus.PSEL), 32'd0);
        chk("rst_penable", 32'(bus.PENABLE), 32'd0);
        chk("rst_pwrite", 32'(bus.PWRITE), 32'd0);
        chk("rst_paddr", 32'(bus.PADDR), 32'd0);
        chk("rst_pwdata", bus.PWDATA, 32'd0);
        chk("rst_rspvalid", 32'(bus.RSPVALID), 32'd0);
        chk("rst_rsp", {bus.RSPRDATA[29:0], bus.RSPERR, bus.RSPTO}, 32'd0);
        PRESET = 1'b0;
        #1 chk("rel_cmdready", 32'(bus.CMDREADY), 32'd1);
        @(negedge PCLK); aborting = 1'b0;
        @(posedge PCLK); #1;

        issue(mk(12'h00C, 1'b1, 32'hDEADBEEF, 0, 1'b0, 32'hA5A5A5A5, 0)); drain();
        issue(mk(12'h004, 1'b0, 32'h0, 3, 1'b0, 32'h12345678, 1)); drain();
        issue(mk(12'h010, 1'b0, 32'h0, 1000, 1'b0, 32'hFFFFFFFF, 0)); drain();
        issue(mk(12'h020, 1'b1, 32'hCAFEF00D, 1, 1'b1, 32'h0, 5)); drain();
        issue(mk(12'h030, 1'b0, 32'h0, TIMEOUT - 1, 1'b0, 32'h600DF00D, 0)); drain();

        // Reset while the completer is inserting wait states.
        issue(mk(12'h040, 1'b0, 32'h0, 10, 1'b0, 32'h0BADBAD0, 0));
        n = 0;
        do begin @(negedge PCLK); n++; end while (!(bus.PSEL && bus.PENABLE) && n < 50);
        if (!(bus.PSEL && bus.PENABLE)) failNow("reach_access");
        repeat (2) @(negedge PCLK);
        aborting = 1'b1; PRESET = 1'b1;
        @(negedge PCLK);
        chk("abort_psel", 32'(bus.PSEL), 32'd0);
        chk("abort_penable", 32'(bus.PENABLE), 32'd0);
        chk("abort_rspvalid", 32'(bus.RSPVALID), 32'd0);
        chk("abort_cmdready", 32'(bus.CMDREADY), 32'd0);
        expQ.delete(); planQ.delete();
        lastAddr = '0; lastWdata = '0;
        PRESET = 1'b0;
        #1 chk("abort_rel_cmdready", 32'(bus.CMDREADY), 32'd1);
        repeat (2) @(negedge PCLK);
        chk("abort_no_rsp", 32'(bus.RSPVALID), 32'd0);
        aborting = 1'b0;
        @(posedge PCLK); #1;

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            waits = (r < 7) ? $urandom_range(0, 3) : (r == 7) ? TIMEOUT - 1 :
                    (r == 8) ? TIMEOUT : $urandom_range(TIMEOUT + 1, TIMEOUT + 6);
            p = mk(AW'($urandom), 1'($urandom), $urandom, waits,
                   1'($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge PCLK);
                #1;
            end
            issue(p);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=still running expected=finished (cycle %0d)", cyc);
        $fatal(1, "simulation time limit");
    end

endmodule
